// File: rtl/exc_commit_ctrl.sv
// exc_commit_ctrl
// MEM-stage exception arbiter and pipeline redirect controller. It sits in
// front of the CP0 register file. It picks the highest-priority event attached
// to the MEM instruction: an interrupt, a synchronous exception or ERET. It then
// issues a one-cycle CP0 commit with a pipeline flush. After that it holds a
// redirect PC until fetch accepts it.
//
// Optional build macro: EXC_BADVADDR_EN
//   Adds the mem_badaddr_i input and the cp0_badvaddr_we_o / cp0_badvaddr_o
//   outputs. BadVAddr is committed for address-error exceptions only.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mem_valid_i         MEM stage holds a valid instruction
//   mem_pc_i            PC of the MEM instruction
//   mem_in_delayslot_i  MEM instruction sits in a branch delay slot
//   mem_exc_i[7:0]      exception flags: fetch AdEL, RI, Ov, Syscall, Break,
//                       load AdEL, store AdES, ERET (bit 0 .. bit 7)
//   cp0_status_i/cause_i/epc_i   architectural CP0 state
//   wb_cp0_we_i/waddr_i/data_i   in-flight WB mtc0, forwarded onto CP0 state
//   if_ready_i          fetch accepts the redirect
//   flush_o, stall_o    pipeline control
//   cp0_exc_we_o, cp0_exc_code_o, cp0_epc_wdata_o, cp0_bd_o   exception commit
//   cp0_eret_o          ERET commit (CP0 clears Status.EXL)
//   new_pc_valid_o, new_pc_o     redirect handshake to fetch
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] EPC_DS_ADJ = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  input  logic        if_ready_i,
`ifdef EXC_BADVADDR_EN
  input  logic [31:0] mem_badaddr_i,
  output logic        cp0_badvaddr_we_o,
  output logic [31:0] cp0_badvaddr_o,
`endif
  output logic        flush_o,
  output logic        stall_o,
  output logic        cp0_exc_we_o,
  output logic [4:0]  cp0_exc_code_o,
  output logic [31:0] cp0_epc_wdata_o,
  output logic        cp0_bd_o,
  output logic        cp0_eret_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      r_state;
  logic        r_flush, r_stall, r_exc_we, r_bd, r_eret, r_pc_valid;
  logic [4:0]  r_code;
  logic [31:0] r_epc_wdata, r_target, r_new_pc;

  // Effective CP0 fields: a WB-stage mtc0 has not reached CP0 yet, so its
  // data overrides the architectural value. Only Cause.IP[1:0] is writable.
  logic        w_fwd_status, w_fwd_cause, w_fwd_epc;
  logic [7:0]  w_im, w_ip;
  logic        w_ie, w_exl;
  logic [31:0] w_epc;
  logic        w_int_pending;

  assign w_fwd_status = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd12);
  assign w_fwd_cause  = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd13);
  assign w_fwd_epc    = wb_cp0_we_i && (wb_cp0_waddr_i == 5'd14);

  assign w_im  = w_fwd_status ? wb_cp0_data_i[15:8] : cp0_status_i[15:8];
  assign w_ie  = w_fwd_status ? wb_cp0_data_i[0]    : cp0_status_i[0];
  assign w_exl = w_fwd_status ? wb_cp0_data_i[1]    : cp0_status_i[1];
  assign w_ip  = {cp0_cause_i[15:10],
                  w_fwd_cause ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8]};
  assign w_epc = w_fwd_epc ? wb_cp0_data_i : cp0_epc_i;

  assign w_int_pending = (|(w_ip & w_im)) && w_ie && !w_exl;

  // Architectural bits that never influence arbitration.
  logic w_unused;
  assign w_unused = &{1'b0, cp0_status_i[31:16], cp0_status_i[7:2],
                      cp0_cause_i[31:16], cp0_cause_i[7:0]};

  // Priority encoder. The interrupt outranks everything and ERET ranks last,
  // so ERET is only taken when no exception source is active.
  logic        w_exc_hit;
  logic [4:0]  w_code;
  logic        w_eret_hit;
  logic        w_detect;
  logic [31:0] w_epc_wdata;
`ifdef EXC_BADVADDR_EN
  logic        w_bv_hit;
  logic [31:0] w_bv_val;
  logic        r_bv_we;
  logic [31:0] r_bv;
`endif

  always_comb begin
    w_exc_hit = 1'b1;
    w_code    = 5'h00;
`ifdef EXC_BADVADDR_EN
    w_bv_hit  = 1'b0;
    w_bv_val  = mem_pc_i;
`endif
    if (w_int_pending) begin
      w_code = 5'h00;
    end else if (mem_exc_i[0]) begin
      w_code = 5'h04;
`ifdef EXC_BADVADDR_EN
      w_bv_hit = 1'b1;
`endif
    end else if (mem_exc_i[1]) begin
      w_code = 5'h0a;
    end else if (mem_exc_i[2]) begin
      w_code = 5'h0c;
    end else if (mem_exc_i[3]) begin
      w_code = 5'h08;
    end else if (mem_exc_i[4]) begin
      w_code = 5'h09;
    end else if (mem_exc_i[5]) begin
      w_code = 5'h04;
`ifdef EXC_BADVADDR_EN
      w_bv_hit = 1'b1;
      w_bv_val = mem_badaddr_i;
`endif
    end else if (mem_exc_i[6]) begin
      w_code = 5'h05;
`ifdef EXC_BADVADDR_EN
      w_bv_hit = 1'b1;
      w_bv_val = mem_badaddr_i;
`endif
    end else begin
      w_exc_hit = 1'b0;
    end
  end

  assign w_eret_hit  = !w_exc_hit && mem_exc_i[7];
  assign w_detect    = (r_state == IDLE) && mem_valid_i && (w_exc_hit || w_eret_hit);
  assign w_epc_wdata = mem_in_delayslot_i ? (mem_pc_i - EPC_DS_ADJ) : mem_pc_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush     <= 1'b0;
      r_stall     <= 1'b0;
      r_exc_we    <= 1'b0;
      r_code      <= 5'h00;
      r_epc_wdata <= 32'h0;
      r_bd        <= 1'b0;
      r_eret      <= 1'b0;
      r_pc_valid  <= 1'b0;
      r_target    <= 32'h0;
      r_new_pc    <= 32'h0;
`ifdef EXC_BADVADDR_EN
      r_bv_we     <= 1'b0;
      r_bv        <= 32'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_detect) begin
            r_state     <= FLUSH;
            r_flush     <= 1'b1;
            r_stall     <= 1'b1;
            r_exc_we    <= w_exc_hit;
            r_eret      <= w_eret_hit;
            r_code      <= w_exc_hit ? w_code : 5'h00;
            r_epc_wdata <= w_exc_hit ? w_epc_wdata : 32'h0;
            r_bd        <= w_exc_hit && mem_in_delayslot_i;
            // EPC is captured now because the redirect happens two cycles
            // later and CP0 or WB may change by then.
            r_target    <= w_exc_hit ? EXC_VECTOR : w_epc;
`ifdef EXC_BADVADDR_EN
            r_bv_we     <= w_exc_hit && w_bv_hit;
            r_bv        <= (w_exc_hit && w_bv_hit) ? w_bv_val : 32'h0;
`endif
          end
        end
        FLUSH: begin
          r_state     <= REDIRECT;
          r_flush     <= 1'b0;
          r_exc_we    <= 1'b0;
          r_eret      <= 1'b0;
          r_code      <= 5'h00;
          r_epc_wdata <= 32'h0;
          r_bd        <= 1'b0;
          r_pc_valid  <= 1'b1;
          r_new_pc    <= r_target;
`ifdef EXC_BADVADDR_EN
          r_bv_we     <= 1'b0;
          r_bv        <= 32'h0;
`endif
        end
        REDIRECT: begin
          if (if_ready_i) begin
            r_state    <= IDLE;
            r_stall    <= 1'b0;
            r_pc_valid <= 1'b0;
            r_new_pc   <= 32'h0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flush_o         = r_flush;
  assign stall_o         = r_stall;
  assign cp0_exc_we_o    = r_exc_we;
  assign cp0_exc_code_o  = r_code;
  assign cp0_epc_wdata_o = r_epc_wdata;
  assign cp0_bd_o        = r_bd;
  assign cp0_eret_o      = r_eret;
  assign new_pc_valid_o  = r_pc_valid;
  assign new_pc_o        = r_new_pc;
`ifdef EXC_BADVADDR_EN
  assign cp0_badvaddr_we_o = r_bv_we;
  assign cp0_badvaddr_o    = r_bv;
`endif

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- MEM-stage exception arbiter and pipeline redirect controller; sits directly upstream of the CP0 register file.
- Consumes CP0 Status/Cause/EPC plus MEM-stage exception flags and picks the highest-priority event.
- Produces one-cycle CP0 commit commands (EPC/Cause/EXL update or ERET), a pipeline flush, and a handshaked redirect PC to fetch.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC
- EPC_DS_ADJ, 32'd4, subtracted from PC for delay-slot instructions

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid_i  in  1  MEM holds a valid instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_exc_i  in  8  flags: [0] fetch AdEL, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] load AdEL, [6] store AdES, [7] ERET
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  WB-stage mtc0 write enable (forwarding)
- wb_cp0_waddr_i  in  5  WB mtc0 register number
- wb_cp0_data_i  in  32  WB mtc0 data
- if_ready_i  in  1  fetch accepts redirect
- flush_o  out  1  flush IF..MEM
- stall_o  out  1  hold pipeline while redirect is pending
- cp0_exc_we_o  out  1  commit exception: CP0 writes EPC, Cause.ExcCode, Cause.BD and sets Status.EXL
- cp0_exc_code_o  out  5  ExcCode
- cp0_epc_wdata_o  out  32  EPC value
- cp0_bd_o  out  1  Cause.BD value
- cp0_eret_o  out  1  commit ERET: CP0 clears Status.EXL
- new_pc_valid_o  out  1  redirect valid
- new_pc_o  out  32  redirect target

Behaviour:
- Forwarding for the effective CP0 values:
  - wb_cp0_we_i with waddr 12: status = wb_cp0_data_i.
  - waddr 13: cause[9:8] = wb data[9:8]; other cause bits come from cp0_cause_i.
  - waddr 14: epc = wb_cp0_data_i.
- Interrupt pending = |(cause[15:8] & status[15:8]) && status[0] && !status[1].
- Detection only in IDLE with mem_valid_i=1.
- Priority and codes, highest first:
  - interrupt 0x00
  - fetch AdEL 0x04
  - RI 0x0a
  - Ov 0x0c
  - Syscall 0x08
  - Break 0x09
  - load AdEL 0x04
  - store AdES 0x05
  - ERET (no code)
- Interrupt is attached to the MEM instruction; that instruction does not complete.
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE, event detected at cycle N: registered decision, go to FLUSH.
  - FLUSH (cycle N+1):
    - flush_o=1, stall_o=1.
    - For an exception: cp0_exc_we_o=1 with code, cp0_epc_wdata_o = mem_in_delayslot ? pc-EPC_DS_ADJ : pc, and cp0_bd_o=in_delayslot.
    - For ERET: cp0_eret_o=1.
    - Exactly one cycle, then REDIRECT.
  - REDIRECT:
    - stall_o=1, new_pc_valid_o=1.
    - new_pc_o = EXC_VECTOR for an exception, or the forwarded EPC latched at N for ERET.
    - new_pc_o is stable until if_ready_i=1; on that cycle go to IDLE, and new_pc_valid_o drops the next cycle.
    - Minimum redirect latency is 2 cycles after detection.
- if_ready_i is ignored outside REDIRECT.
- All MEM inputs are ignored outside IDLE; no queuing.
- Multiple flags set at once: only the highest-priority one is taken.
- ERET together with any exception flag: the exception wins.
- Reset values: state IDLE; every output 0, including new_pc_o = 0.
- rst in FLUSH or REDIRECT: abort to IDLE next edge, no CP0 commit, all outputs 0.

Optional Feature:
- Macro: EXC_BADVADDR_EN.
- Defined:
  - Adds input mem_badaddr_i (32) and outputs cp0_badvaddr_we_o (1) and cp0_badvaddr_o (32).
  - The badvaddr outputs assert in FLUSH alongside cp0_exc_we_o, for address errors only.
  - Value: mem_pc_i for fetch AdEL, mem_badaddr_i for load/store.
- Undefined: these ports are absent; no BadVAddr logic.

Test Plan:
- mem_exc_i=8'h08, pc=0xBFC00100, not delay slot -> FLUSH cycle: cp0_exc_we_o=1, code=0x08, epc=0xBFC00100, bd=0; REDIRECT: new_pc=0xBFC00380, held 3 cycles until if_ready_i=1, then IDLE.
- Ov (8'h04) in delay slot, pc=0x80000024 -> epc=0x80000020, bd=1, code=0x0c.
- ERET with cp0_epc_i=0x80001000 and same-cycle WB mtc0 EPC=0x80002000 -> cp0_eret_o=1 for one cycle, new_pc=0x80002000, cp0_exc_we_o=0.
- status=0x0000FF01, cause[10]=1, mem_exc_i=8'h02 (RI) -> interrupt wins, code=0x00.
- Same case with status[1]=1 (EXL) -> RI taken, code=0x0a; with WB mtc0 Cause data[8]=1, status[8]=1, status[1]=0 -> interrupt taken.
- rst asserted during REDIRECT -> next cycle all outputs 0, IDLE; a new Break two cycles later is handled normally.
